// File: rtl/alu_vec_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : alu_vec_pipe
//  Description : LANES-wide vector ALU behind a single valid/ready interface.
//                Lane results, compare flags and per-lane MAC accumulators are
//                computed combinationally into stage 1. The result then moves
//                through a DEPTH-stage elastic pipeline.
//                Optional macro ALU_VEC_PIPE_SIGNED_EN adds a signed_mode input
//                that selects two's-complement arithmetic.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_vec_pipe #(
    parameter int LANES = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               opcode,
    input  logic [LANES-1:0]         lane_mask,
    input  logic [LANES*WIDTH-1:0]   a,
    input  logic [LANES*WIDTH-1:0]   b,
`ifdef ALU_VEC_PIPE_SIGNED_EN
    input  logic                     signed_mode,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*2*WIDTH-1:0] result,
    output logic [LANES-1:0]         a_greater,
    output logic [LANES-1:0]         a_equal,
    output logic [LANES-1:0]         a_less,
    output logic [LANES-1:0]         out_mask
);

    localparam int RW  = 2 * WIDTH;
    localparam int SHW = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_NOT  = 4'd6;
    localparam logic [3:0] OP_SHL  = 4'd7;
    localparam logic [3:0] OP_SHR  = 4'd8;
    localparam logic [3:0] OP_MIN  = 4'd9;
    localparam logic [3:0] OP_MAX  = 4'd10;
    localparam logic [3:0] OP_PASS = 4'd11;
    localparam logic [3:0] OP_MAC  = 4'd12;
    localparam logic [3:0] OP_CLR  = 4'd13;

    logic             sgn;
    logic             accept;
    logic             go;
    logic [DEPTH-1:0] move;

    logic [LANES*RW-1:0] lane_res;
    logic [LANES-1:0]    lane_gt;
    logic [LANES-1:0]    lane_eq;
    logic [LANES-1:0]    lane_lt;

    logic [DEPTH-1:0]    vld_q, vld_d;
    logic [LANES*RW-1:0] res_q [DEPTH];
    logic [LANES*RW-1:0] res_d [DEPTH];
    logic [LANES-1:0]    gt_q  [DEPTH];
    logic [LANES-1:0]    gt_d  [DEPTH];
    logic [LANES-1:0]    eq_q  [DEPTH];
    logic [LANES-1:0]    eq_d  [DEPTH];
    logic [LANES-1:0]    lt_q  [DEPTH];
    logic [LANES-1:0]    lt_d  [DEPTH];
    logic [LANES-1:0]    msk_q [DEPTH];
    logic [LANES-1:0]    msk_d [DEPTH];

`ifdef ALU_VEC_PIPE_SIGNED_EN
    assign sgn = signed_mode;
`else
    assign sgn = 1'b0;
`endif

    // Stage move chain from the output back to stage 1: a stage advances when
    // it holds data and the stage after it is empty or itself advancing.
    always_comb begin
        move = '0;
        go   = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            move[k] = vld_q[k] & go;
            go      = ~vld_q[k] | move[k];
        end
    end

    // Ready depends only on pipeline state and out_ready, never on in_valid.
    assign in_ready = ~rst & (~vld_q[0] | move[0]);
    assign accept   = in_valid & in_ready;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [WIDTH-1:0] op_a, op_b;
        logic [RW-1:0]    ax, bx, prod, res;
        logic [RW-1:0]    acc_q, acc_d;
        logic [SHW-1:0]   sh;
        logic             a_lt, a_eq;

        assign op_a = a[l*WIDTH +: WIDTH];
        assign op_b = b[l*WIDTH +: WIDTH];
        assign ax   = sgn ? {{WIDTH{op_a[WIDTH-1]}}, op_a} : {{WIDTH{1'b0}}, op_a};
        assign bx   = sgn ? {{WIDTH{op_b[WIDTH-1]}}, op_b} : {{WIDTH{1'b0}}, op_b};
        assign sh   = op_b[SHW-1:0];
        // Low RW bits of the product are correct for both extensions.
        assign prod = ax * bx;
        // Zero-extended operands have a clear top bit, so one signed compare
        // serves both modes.
        assign a_lt = $signed(ax) < $signed(bx);
        assign a_eq = (ax == bx);

        // Lane result select and accumulator next value (only on accept).
        always_comb begin
            res   = '0;
            acc_d = acc_q;
            case (opcode)
                OP_ADD:  res = ax + bx;
                OP_SUB:  res = ax - bx;
                OP_MUL:  res = prod;
                OP_AND:  res = ax & bx;
                OP_OR:   res = ax | bx;
                OP_XOR:  res = ax ^ bx;
                OP_NOT:  res = {{WIDTH{1'b0}}, ~op_a};
                OP_SHL:  res = ax << sh;
                OP_SHR:  res = $signed(ax) >>> sh;
                OP_MIN:  res = a_lt ? ax : bx;
                OP_MAX:  res = a_lt ? bx : ax;
                OP_PASS: res = bx;
                OP_MAC: begin
                    res = acc_q + prod;
                    if (accept) acc_d = res;
                end
                OP_CLR: begin
                    res = '0;
                    if (accept) acc_d = '0;
                end
                default: res = '0;
            endcase
            if (!lane_mask[l]) begin
                res   = '0;
                acc_d = acc_q;
            end
        end

        // Per-lane accumulator register.
        always_ff @(posedge clk) begin
            if (rst) acc_q <= '0;
            else     acc_q <= acc_d;
        end

        assign lane_res[l*RW +: RW] = res;
        assign lane_gt[l] = lane_mask[l] & ~a_lt & ~a_eq;
        assign lane_eq[l] = lane_mask[l] & a_eq;
        assign lane_lt[l] = lane_mask[l] & a_lt;
    end

    // Next-state of every pipeline stage: load from upstream when it moves,
    // otherwise drain the valid bit when this stage moves on.
    always_comb begin
        vld_d = vld_q;
        for (int k = 0; k < DEPTH; k++) begin
            res_d[k] = res_q[k];
            gt_d[k]  = gt_q[k];
            eq_d[k]  = eq_q[k];
            lt_d[k]  = lt_q[k];
            msk_d[k] = msk_q[k];
        end
        if (accept) begin
            vld_d[0] = 1'b1;
            res_d[0] = lane_res;
            gt_d[0]  = lane_gt;
            eq_d[0]  = lane_eq;
            lt_d[0]  = lane_lt;
            msk_d[0] = lane_mask;
        end else if (move[0]) begin
            vld_d[0] = 1'b0;
        end
        for (int k = 1; k < DEPTH; k++) begin
            if (move[k-1]) begin
                vld_d[k] = 1'b1;
                res_d[k] = res_q[k-1];
                gt_d[k]  = gt_q[k-1];
                eq_d[k]  = eq_q[k-1];
                lt_d[k]  = lt_q[k-1];
                msk_d[k] = msk_q[k-1];
            end else if (move[k]) begin
                vld_d[k] = 1'b0;
            end
        end
    end

    // Pipeline stage registers; reset discards anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                res_q[k] <= '0;
                gt_q[k]  <= '0;
                eq_q[k]  <= '0;
                lt_q[k]  <= '0;
                msk_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int k = 0; k < DEPTH; k++) begin
                res_q[k] <= res_d[k];
                gt_q[k]  <= gt_d[k];
                eq_q[k]  <= eq_d[k];
                lt_q[k]  <= lt_d[k];
                msk_q[k] <= msk_d[k];
            end
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign result    = res_q[DEPTH-1];
    assign a_greater = gt_q[DEPTH-1];
    assign a_equal   = eq_q[DEPTH-1];
    assign a_less    = lt_q[DEPTH-1];
    assign out_mask  = msk_q[DEPTH-1];

endmodule
`default_nettype wire

// File: tb/tb_alu_vec_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_vec_pipe
//  Description : Scoreboard bench for alu_vec_pipe with an integer reference
//                model, directed scenarios and randomized backpressure.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_vec_pipe;
    localparam int LANES = 4;
    localparam int WIDTH = 8;
    localparam int DEPTH = 2;
    localparam int RW    = 2 * WIDTH;

    typedef struct {
        logic [LANES*RW-1:0] res;
        logic [LANES-1:0]    gt;
        logic [LANES-1:0]    eq;
        logic [LANES-1:0]    lt;
        logic [LANES-1:0]    msk;
        int                  cyc;
        bit                  strict;
    } item_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [3:0]             opcode = '0;
    logic [LANES-1:0]       lane_mask = '0;
    logic [LANES*WIDTH-1:0] a = '0;
    logic [LANES*WIDTH-1:0] b = '0;
    logic                   sm_drv = 1'b0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [LANES*RW-1:0]    result;
    logic [LANES-1:0]       a_greater, a_equal, a_less, out_mask;

    item_t         exp_q[$];
    logic [RW-1:0] acc_m [LANES];
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            ordy_mode = 0;
    bit            strict = 1'b0;

    alu_vec_pipe #(.LANES(LANES), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .lane_mask(lane_mask), .a(a), .b(b),
`ifdef ALU_VEC_PIPE_SIGNED_EN
        .signed_mode(sm_drv),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .a_greater(a_greater), .a_equal(a_equal), .a_less(a_less),
        .out_mask(out_mask)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Reference model: integer arithmetic on the operand values, reduced mod 2^RW.
    function automatic item_t model(input logic [3:0] op, input logic [LANES-1:0] m,
                                    input logic [LANES*WIDTH-1:0] av,
                                    input logic [LANES*WIDTH-1:0] bv, input logic sm);
        item_t it;
        it.res = '0; it.gt = '0; it.eq = '0; it.lt = '0; it.msk = m;
        it.cyc = cyc; it.strict = strict;
        for (int l = 0; l < LANES; l++) begin
            int x, y, r, sh;
            logic [WIDTH-1:0] ua, ub;
            ua = av[l*WIDTH +: WIDTH];
            ub = bv[l*WIDTH +: WIDTH];
            x  = sm ? int'($signed(ua)) : int'(ua);
            y  = sm ? int'($signed(ub)) : int'(ub);
            sh = int'(ub) % (1 << ($clog2(WIDTH) + 1));
            case (op)
                4'd0:  r = x + y;
                4'd1:  r = x - y;
                4'd2:  r = x * y;
                4'd3:  r = x & y;
                4'd4:  r = x | y;
                4'd5:  r = x ^ y;
                4'd6:  r = (~x) & ((1 << WIDTH) - 1);
                4'd7:  r = x << sh;
                4'd8:  r = x >>> sh;
                4'd9:  r = (x < y) ? x : y;
                4'd10: r = (x < y) ? y : x;
                4'd11: r = y;
                4'd12: r = int'(acc_m[l]) + x * y;
                default: r = 0;
            endcase
            if (m[l]) begin
                it.res[l*RW +: RW] = r[RW-1:0];
                it.gt[l] = (x > y);
                it.eq[l] = (x == y);
                it.lt[l] = (x < y);
                if (op == 4'd12) acc_m[l] = r[RW-1:0];
                if (op == 4'd13) acc_m[l] = '0;
            end
        end
        return it;
    endfunction

    task automatic set_ordy();
        case (ordy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    endtask

    // in_ready must drop only when every stage is occupied and the sink stalls.
    task automatic check_ready();
        logic exp_rdy;
        exp_rdy = !(exp_q.size() == DEPTH && !out_ready);
        checks++;
        if (in_ready !== exp_rdy) begin
            failures++;
            $display("FAIL in_ready got=%b exp=%b occ=%0d out_ready=%b", in_ready, exp_rdy,
                     exp_q.size(), out_ready);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        set_ordy();
        #1;
        check_ready();
    endtask

    task automatic issue(input logic [3:0] op, input logic [LANES-1:0] m,
                         input logic [LANES*WIDTH-1:0] av, input logic [LANES*WIDTH-1:0] bv,
                         input bit use_exp, input logic [LANES*RW-1:0] exp_res);
        item_t it;
        bit    done;
        int    tries;
        done = 1'b0;
        tries = 0;
        while (!done && tries < 200) begin
            @(negedge clk);
            in_valid = 1'b1; opcode = op; lane_mask = m; a = av; b = bv;
            set_ordy();
            #1;
            check_ready();
            if (in_ready) begin
                it = model(op, m, av, bv, sm_drv);
                if (use_exp) it.res = exp_res;
                exp_q.push_back(it);
                done = 1'b1;
            end
            tries++;
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL issue_timeout got=no_accept exp=accept op=%0d", op);
        end else if (strict) begin
            checks++;
            if (tries != 1) begin
                failures++;
                $display("FAIL back_to_back got=%0d tries exp=1", tries);
            end
        end
    endtask

    task automatic drain();
        int t;
        ordy_mode = 0;
        t = 0;
        while (exp_q.size() > 0 && t < 100) begin
            idle();
            t++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d pending exp=0", exp_q.size());
        end
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL rst_in_ready got=%b exp=0", in_ready);
            end
            if (i > 0) begin
                checks++;
                if (out_valid !== 1'b0 || result !== '0 || out_mask !== '0) begin
                    failures++;
                    $display("FAIL rst_outputs got=%b/%h/%b exp=0/0/0", out_valid, result, out_mask);
                end
            end
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        for (int l = 0; l < LANES; l++) acc_m[l] = '0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_rst got=rdy%b vld%b exp=rdy1 vld0", in_ready, out_valid);
        end
    endtask

    // Monitor: pops the oldest expectation on every delivery and checks that
    // stalled outputs stay put.
    initial begin : monitor
        item_t               e;
        logic                stall_prev;
        logic [LANES*RW-1:0] p_res;
        logic [4*LANES-1:0]  p_fl;
        stall_prev = 1'b0;
        p_res = '0;
        p_fl = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    checks++;
                    if (out_valid !== 1'b1 || result !== p_res ||
                        {a_greater, a_equal, a_less, out_mask} !== p_fl) begin
                        failures++;
                        $display("FAIL stall_hold got=%b/%h exp=1/%h", out_valid, result, p_res);
                    end
                end
                if (out_valid === 1'b1 && out_ready === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_output got=%h exp=none", result);
                    end else begin
                        e = exp_q.pop_front();
                        if (result !== e.res) begin
                            failures++;
                            $display("FAIL result got=%h exp=%h", result, e.res);
                        end
                        checks++;
                        if ({a_greater, a_equal, a_less} !== {e.gt, e.eq, e.lt}) begin
                            failures++;
                            $display("FAIL flags got=%b exp=%b", {a_greater, a_equal, a_less},
                                     {e.gt, e.eq, e.lt});
                        end
                        checks++;
                        if (out_mask !== e.msk) begin
                            failures++;
                            $display("FAIL out_mask got=%b exp=%b", out_mask, e.msk);
                        end
                        checks++;
                        if ((e.strict && (cyc - e.cyc) != DEPTH) || (cyc - e.cyc) < DEPTH) begin
                            failures++;
                            $display("FAIL latency got=%0d exp=%0d", cyc - e.cyc, DEPTH);
                        end
                    end
                end
                stall_prev = (out_valid === 1'b1) && (out_ready === 1'b0);
                p_res = result;
                p_fl  = {a_greater, a_equal, a_less, out_mask};
            end
        end
    end

    initial begin : stimulus
        do_reset();

        // Streaming ADD with a carry out of every lane.
        strict = 1'b1;
        ordy_mode = 0;
        for (int i = 0; i < 10; i++)
            issue(4'd0, 4'hF, {4{8'hFF}}, {4{8'h01}}, 1'b1, {4{16'h0100}});
        drain();
        strict = 1'b0;

        // MAC chain, then the same chain with lane 1 masked on the second MAC.
        issue(4'd13, 4'hF, {4{8'h0A}}, {4{8'h14}}, 1'b1, '0);
        issue(4'd12, 4'hF, {4{8'h0A}}, {4{8'h14}}, 1'b1, {4{16'd200}});
        issue(4'd12, 4'hF, {4{8'h0A}}, {4{8'h14}}, 1'b1, {4{16'd400}});
        issue(4'd12, 4'hF, {4{8'h0A}}, {4{8'h14}}, 1'b1, {4{16'd600}});
        issue(4'd13, 4'hF, {4{8'h0A}}, {4{8'h14}}, 1'b1, '0);
        issue(4'd12, 4'hF, {4{8'h0A}}, {4{8'h14}}, 1'b1, {4{16'd200}});
        issue(4'd12, 4'b1101, {4{8'h0A}}, {4{8'h14}}, 1'b1,
              {16'd400, 16'd400, 16'd0, 16'd400});
        issue(4'd12, 4'hF, {4{8'h0A}}, {4{8'h14}}, 1'b1,
              {16'd600, 16'd600, 16'd400, 16'd600});

        // Masked SUB that wraps below zero.
        issue(4'd1, 4'b0101, {4{8'h03}}, {4{8'h05}}, 1'b1,
              {16'h0000, 16'hFFFE, 16'h0000, 16'hFFFE});
        drain();

        // Randomized ops under 50% backpressure.
        ordy_mode = 1;
        for (int i = 0; i < 200; i++) begin
`ifdef ALU_VEC_PIPE_SIGNED_EN
            sm_drv = 1'($urandom_range(0, 1));
`endif
            if ($urandom_range(0, 3) == 0) idle();
            issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  32'($urandom), 32'($urandom), 1'b0, '0);
        end
        sm_drv = 1'b0;
        drain();

        // Reset with a full pipeline; accumulators must restart from zero.
        ordy_mode = 0;
        issue(4'd12, 4'hF, {4{8'h33}}, {4{8'h07}}, 1'b0, '0);
        ordy_mode = 2;
        issue(4'd12, 4'hF, {4{8'h21}}, {4{8'h05}}, 1'b0, '0);
        idle();
        do_reset();
        ordy_mode = 0;
        issue(4'd12, 4'hF, {4{8'h01}}, {4{8'h01}}, 1'b1, {4{16'h0001}});
        drain();

`ifdef ALU_VEC_PIPE_SIGNED_EN
        sm_drv = 1'b1;
        issue(4'd2, 4'hF, {4{8'hFF}}, {4{8'h02}}, 1'b1, {4{16'hFFFE}});
        issue(4'd8, 4'hF, {4{8'h80}}, {4{8'h01}}, 1'b1, {4{16'hFFC0}});
        drain();
        sm_drv = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
